// File: rtl/ikaopll_op.sv
// OPLL operator: phase modulation, log-sine lookup, attenuation and exponential
// conversion in a 3-stage pipeline, plus the output history used for modulation/feedback.
module ikaopll_op (
  input  logic               i_EMUCLK,
  input  logic               i_IC_n,
  input  logic               i_phi1_NCEN_n,
  input  logic               i_CYCLE_00,
  input  logic               i_MnC_SEL,
  input  logic [9:0]         i_PHASE,
  input  logic [2:0]         i_FB,
  input  logic               i_DM,
  input  logic               i_DC,
  input  logic [6:0]         i_OP_ATTNLV,
  input  logic               i_OP_ATTNLV_MAX,
  output logic signed [12:0] o_OP_OUT
);

  // hist_q[k] holds the output of the slot 3+k slots before the one entering stage 1
  localparam int  HIST_DEPTH = 34;
  localparam real PI         = 3.14159265358979323846;

  function automatic int logsin_val(input int i);
    real ang;
    ang = ($itor(2 * i + 1) * PI) / 1024.0;
    return $rtoi(-($ln($sin(ang)) / $ln(2.0)) * 256.0 + 0.5);
  endfunction

  function automatic int exp_val(input int j);
    return $rtoi(($pow(2.0, $itor(j) / 256.0) - 1.0) * 1024.0 + 0.5);
  endfunction

  logic [11:0] logsin_rom [256];
  logic [9:0]  exp_rom    [256];

  for (genvar gi = 0; gi < 256; gi++) begin : g_rom
    localparam int LS = logsin_val(gi);
    localparam int EX = exp_val(gi);
    assign logsin_rom[gi] = LS[11:0];
    assign exp_rom[gi]    = EX[9:0];
  end

  logic en;
  logic unused_cycle;
  assign en           = ~i_phi1_NCEN_n;
  assign unused_cycle = i_CYCLE_00;

  logic signed [12:0] hist_q [HIST_DEPTH];

  // Stage 0: modulation source and phase sum
  logic signed [13:0] fb_sum;
  logic [9:0]         fb_mod, car_mod, mod_val, phase_d;

  always_comb begin
    fb_sum  = {hist_q[15][12], hist_q[15]} + {hist_q[33][12], hist_q[33]};
    fb_mod  = 10'(fb_sum >>> (4'd9 - {1'b0, i_FB}));
    car_mod = 10'(hist_q[0] >>> 1);
    mod_val = '0;
    if (i_MnC_SEL) begin
      if (i_FB != 3'd0) mod_val = fb_mod;
    end else begin
      mod_val = car_mod;
    end
    phase_d = i_PHASE + mod_val;
  end

  logic [9:0] phase_p1_q;
  logic       mnc_p1_q, zsel_p1_q, vld_p1_q;

  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      phase_p1_q <= '0;
      mnc_p1_q   <= 1'b0;
      zsel_p1_q  <= 1'b0;
      vld_p1_q   <= 1'b0;
    end else if (en) begin
      phase_p1_q <= phase_d;
      mnc_p1_q   <= i_MnC_SEL;
      zsel_p1_q  <= i_MnC_SEL ? i_DM : i_DC;
      vld_p1_q   <= 1'b1;
    end
  end

  // Stage 1 -> 2: quarter-wave log-sine lookup
  logic [7:0] idx_d;
  assign idx_d = phase_p1_q[8] ? ~phase_p1_q[7:0] : phase_p1_q[7:0];

  logic [11:0] logsin_p2_q;
  logic        sign_p2_q, zero_p2_q, mnc_p2_q, vld_p2_q;

  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      logsin_p2_q <= '0;
      sign_p2_q   <= 1'b0;
      zero_p2_q   <= 1'b0;
      mnc_p2_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
    end else if (en) begin
      logsin_p2_q <= logsin_rom[idx_d];
      sign_p2_q   <= phase_p1_q[9];
      zero_p2_q   <= zsel_p1_q & phase_p1_q[9];
      mnc_p2_q    <= mnc_p1_q;
      vld_p2_q    <= vld_p1_q;
    end
  end

  // Stage 2 -> 3: attenuation, exponential conversion and sign
  logic [12:0]        tot;
  logic [9:0]         expv;
  logic [10:0]        mant;
  logic [11:0]        mag;
  logic signed [12:0] out_d, hist_d;

  always_comb begin
    tot  = {1'b0, logsin_p2_q} + {2'b00, i_OP_ATTNLV, 4'b0000};
    expv = exp_rom[~tot[7:0]];
    mant = {1'b0, expv} + 11'd1024;
    mag  = {mant, 1'b0} >> tot[11:8];
    // slots still filling after reset are silenced so no partial output escapes
    if (tot[12] | i_OP_ATTNLV_MAX | zero_p2_q | ~vld_p2_q) mag = '0;
    out_d  = sign_p2_q ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    hist_d = mnc_p2_q ? out_d : '0;
  end

  logic signed [12:0] out_p3_q;

  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      out_p3_q <= '0;
      for (int k = 0; k < HIST_DEPTH; k++) hist_q[k] <= '0;
    end else if (en) begin
      out_p3_q  <= out_d;
      hist_q[0] <= hist_d;
      for (int k = 1; k < HIST_DEPTH; k++) hist_q[k] <= hist_q[k-1];
    end
  end

  assign o_OP_OUT = out_p3_q;

endmodule

// File: tb/tb_ikaopll_op.sv
// Self-checking bench for ikaopll_op: directed waveform points plus randomized
// slot streams compared against a slot-level behavioural model.
module tb_ikaopll_op;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               ic_n, ncen_n, cyc00, mnc, dm, dc, amax;
  logic [9:0]         phase;
  logic [2:0]         fb;
  logic [6:0]         attn;
  logic signed [12:0] op_out;

  ikaopll_op dut (
    .i_EMUCLK        (clk),
    .i_IC_n          (ic_n),
    .i_phi1_NCEN_n   (ncen_n),
    .i_CYCLE_00      (cyc00),
    .i_MnC_SEL       (mnc),
    .i_PHASE         (phase),
    .i_FB            (fb),
    .i_DM            (dm),
    .i_DC            (dc),
    .i_OP_ATTNLV     (attn),
    .i_OP_ATTNLV_MAX (amax),
    .o_OP_OUT        (op_out)
  );

  int checks = 0;
  int errors = 0;

  int logsin_t [256];
  int exp_t    [256];

  typedef struct {
    int pm;
    bit rect;
    bit is_mod;
  } slot_t;

  slot_t pend[$];   // slots sampled but not yet at the output
  int    hist[$];   // per-slot history value, newest at the back
  int    exp_out;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int wrap1024(input int a);
    return ((a % 1024) + 1024) % 1024;
  endfunction

  // history value of the slot 'back' slots before the one being sampled now
  function automatic int hist_at(input int back);
    return hist[hist.size() - 1 - (back - 3)];
  endfunction

  function automatic int mod_value(input bit is_mod, input int f);
    if (!is_mod) return wrap1024(floor_div(hist_at(3), 2));
    if (f == 0) return 0;
    return wrap1024(floor_div(hist_at(18) + hist_at(36), 1 << (9 - f)));
  endfunction

  function automatic int op_value(input int pm, input bit rect, input int at, input bit mx);
    int q, idx, t, m;
    q   = pm % 512;
    idx = (q < 256) ? q : 511 - q;
    t   = logsin_t[idx] + at * 16;
    if (t >= 4096 || mx || (rect && pm >= 512)) return 0;
    m = ((exp_t[255 - (t % 256)] + 1024) * 2) / (1 << (t / 256));
    return (pm >= 512) ? -m : m;
  endfunction

  task automatic model_reset();
    pend.delete();
    hist.delete();
    for (int k = 0; k < 34; k++) hist.push_back(0);
    exp_out = 0;
  endtask

  task automatic step(input bit en, input string tag);
    slot_t s, o;
    int    r;
    ncen_n = !en;
    if (en) begin
      s.pm     = wrap1024(int'(phase) + mod_value(mnc, int'(fb)));
      s.rect   = mnc ? dm : dc;
      s.is_mod = mnc;
      pend.push_back(s);
      r = 0;
      if (pend.size() == 3) begin
        o = pend.pop_front();
        r = op_value(o.pm, o.rect, int'(attn), amax);
        hist.push_back(o.is_mod ? r : 0);
      end else begin
        hist.push_back(0);
      end
      if (hist.size() > 40) void'(hist.pop_front());
      exp_out = r;
    end
    @(posedge clk);
    #1;
    check(tag, op_out, exp_out);
  endtask

  task automatic set_in(input bit m, input int ph, input int f, input bit d_m, input bit d_c,
                        input int at, input bit mx);
    mnc   = m;
    phase = 10'(ph);
    fb    = 3'(f);
    dm    = d_m;
    dc    = d_c;
    attn  = 7'(at);
    amax  = mx;
  endtask

  task automatic run3(input string tag, input int expv);
    for (int k = 0; k < 3; k++) step(1'b1, tag);
    check(tag, op_out, expv);
  endtask

  task automatic do_reset();
    ic_n = 1'b0;
    #1;
    check("rst_async", op_out, 0);
    model_reset();
    @(negedge clk);
    ic_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int slot;
    int f_pos;
    for (int i = 0; i < 256; i++) begin
      logsin_t[i] = $rtoi(-($ln($sin(($itor(2 * i + 1) * 3.14159265358979323846) / 1024.0))
                            / $ln(2.0)) * 256.0 + 0.5);
      exp_t[i]    = $rtoi(($pow(2.0, $itor(i) / 256.0) - 1.0) * 1024.0 + 0.5);
    end

    ic_n   = 1'b0;
    ncen_n = 1'b1;
    cyc00  = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("reset_state", op_out, 0);
    @(negedge clk);
    ic_n = 1'b1;

    set_in(0, 'h100, 0, 0, 0, 0, 0);
    run3("peak", 4084);
    set_in(0, 'h300, 0, 0, 0, 0, 0);
    run3("neg_half", -4084);
    set_in(0, 'h100, 0, 0, 0, 16, 0);
    run3("attn16", 2042);
    set_in(0, 'h100, 0, 0, 0, 16, 1);
    run3("attn_max", 0);
    set_in(0, 'h300, 0, 0, 1, 0, 0);
    run3("rect_on", 0);
    set_in(0, 'h300, 0, 0, 0, 0, 0);
    run3("rect_off", -4084);

    set_in(0, 'h100, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(1'b0, "hold");
    check("hold_val", op_out, -4084);

    #2;
    do_reset();

    set_in(1, 'h100, 0, 0, 0, 0, 0);
    step(1'b1, "mod_seq");
    set_in(0, 'h100, 0, 0, 0, 0, 0);
    step(1'b1, "mod_seq");
    step(1'b1, "mod_seq");
    check("mod_out", op_out, 4084);
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(1'b1, "mod_seq");
    check("mod_path", op_out, op_value(1018, 1'b0, 0, 1'b0));

    #2;
    do_reset();
    slot  = 0;
    f_pos = 0;
    for (int it = 0; it < 4000; it++) begin
      bit en;
      if (it == 2000) begin
        #3;
        do_reset();
        slot = 0;
      end
      f_pos = slot % 18;
      cyc00 = (f_pos == 0);
      mnc   = ((f_pos % 6) < 3);
      phase = 10'($urandom_range(0, 1023));
      fb    = 3'($urandom_range(0, 7));
      dm    = ($urandom_range(0, 3) == 0);
      dc    = ($urandom_range(0, 3) == 0);
      amax  = ($urandom_range(0, 15) == 0);
      if (amax) attn = 7'd127;
      else if ($urandom_range(0, 3) == 0) attn = 7'($urandom_range(0, 127));
      else attn = 7'($urandom_range(0, 24));
      en = ($urandom_range(0, 4) != 0);
      step(en, "rand");
      if (en) slot++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ikaopll_op.md
IKAOPLL_OP -- requirements
Module: IKAOPLL_op

Interface
REQ-001 SHALL: i_EMUCLK  in  1  emulator master clock; the only clock.
REQ-002 SHALL: i_IC_n  in  1  master reset, asynchronous assert, active-low.
REQ-003 SHALL: i_phi1_NCEN_n  in  1  active-low clock enable; all state advances only on i_EMUCLK edges with it low.
REQ-004 SHALL: i_CYCLE_00  in  1  slot-0 marker, one enable per 18-slot frame.
REQ-005 SHALL: i_MnC_SEL  in  1  1 = current slot is a modulator, 0 = carrier.
REQ-006 SHALL: i_PHASE  in  10  unsigned phase from the phase generator for the current slot.
REQ-007 SHALL: i_FB  in  3  modulator feedback level; 0 = off.
REQ-008 SHALL: i_DM, i_DC  in  1 each  half-rectify enable for modulator and carrier.
REQ-009 SHALL: i_OP_ATTNLV  in  7  attenuation level from the envelope generator; 1 LSB = 0.375 dB.
REQ-010 SHALL: i_OP_ATTNLV_MAX  in  1  attenuation level is 127; silence.
REQ-011 SHALL: o_OP_OUT  out  13  two's-complement operator output.

Function
REQ-012 SHALL: 3-stage pipeline, one slot per enable; o_OP_OUT for a slot is valid exactly 3 enables after its inputs are sampled.
REQ-013 SHALL: keep an output history shift register that advances every enable; modulator slots write their final output, carrier slots write 0.
REQ-014 SHALL: carrier modulation = history entry written 3 slots earlier (same channel's modulator), arithmetic shift right 1, truncated to 10 bits.
REQ-015 SHALL: modulator feedback = history entries written 18 and 36 slots earlier, summed into 14 bits, arithmetic shift right by (9 - i_FB), truncated to 10 bits; forced to 0 when i_FB = 0.
REQ-016 SHALL: stage 1 register: phase_m = (i_PHASE + modulation) mod 1024; no saturation.
REQ-017 SHALL: stage 2 quarter index: phase_m[7:0] when phase_m[8] = 0, otherwise ~phase_m[7:0].
REQ-018 SHALL: stage 2 log-sine value: L = LOGSIN[index], 12 bits, where LOGSIN[i] = round(-log2(sin((2i+1)*pi/1024)) * 256).
REQ-019 SHALL: stage 2 sign = phase_m[9].
REQ-020 SHALL: stage 2 zero flag = (i_MnC_SEL ? i_DM : i_DC) & phase_m[9].
REQ-021 SHALL: stage 3 total T = L + {i_OP_ATTNLV, 4'b0000}, 13-bit unsigned.
REQ-022 SHALL: stage 3 exponent E = EXP[~T[7:0]], 10 bits, where EXP[j] = round((2^(j/256) - 1) * 1024).
REQ-023 SHALL: stage 3 magnitude = ((E + 1024) << 1) >> T[11:8], 12 bits.
REQ-024 SHALL: force magnitude to 0 when T[12] = 1, i_OP_ATTNLV_MAX = 1, or the zero flag is set.
REQ-025 SHALL: o_OP_OUT = sign ? -magnitude : magnitude; magnitude 0 with either sign gives 0.
REQ-026 SHALL: i_OP_ATTNLV and i_OP_ATTNLV_MAX are pipeline-aligned, not free-running: both are sampled in the stage that consumes them, for the same slot as i_PHASE.
REQ-027 SHALL: with i_phi1_NCEN_n high, hold all registers, including the history.
REQ-028 SHALL: i_CYCLE_00 is informational only; the history relies on exactly 18 enables per frame, and no realignment occurs on a frame of another length.

Reset
REQ-029 SHALL: while i_IC_n is low, asynchronously clear every pipeline register and the whole history to 0; o_OP_OUT = 0.
REQ-030 SHALL: after i_IC_n deasserts, the first valid output appears 3 enables later, with feedback and modulation reading 0 until the history is refilled.
REQ-031 SHALL: a reset asserted mid-frame discards in-flight slots and produces no partial outputs.

Verification
REQ-032 SHALL: reset: i_IC_n low mid-operation with o_OP_OUT nonzero -> o_OP_OUT = 0 immediately, before the next clock edge.
REQ-033 SHALL: peak: carrier, i_PHASE = 0x100, attn 0, i_FB = 0, history 0 -> o_OP_OUT = +4084 after 3 enables.
REQ-034 SHALL: negative half: i_PHASE = 0x300, otherwise as REQ-033 -> o_OP_OUT = -4084.
REQ-035 SHALL: attenuation: i_PHASE = 0x100, i_OP_ATTNLV = 16 -> o_OP_OUT = +2042; with i_OP_ATTNLV_MAX = 1 -> o_OP_OUT = 0.
REQ-036 SHALL: half-rectify: carrier, i_DC = 1, i_PHASE = 0x300 -> o_OP_OUT = 0; same stimulus with i_DC = 0 -> -4084.
REQ-037 SHALL: modulation path: modulator slot outputs +4084; the carrier 3 slots later with i_PHASE = 0 -> phase_m = 2042 mod 1024 = 1018, and the output matches a reference model evaluated at phase 1018.
